// File: rtl/vga_sync_receiver_if.sv
// Sync-input and recovered-timing bundle for vga_sync_receiver.
// The master side drives the syncs and the slave side is the receiver.
interface vga_sync_receiver_if;
  logic        Hsync;
  logic        Vsync;
  logic [11:0] Hcount;
  logic [11:0] Vcount;
  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [15:0] err_count;

  modport master (
    output Hsync, Vsync,
    input  Hcount, Vcount, x, y, active, frame_start, locked, err, err_count
  );

  modport slave (
    input  Hsync, Vsync,
    output Hcount, Vcount, x, y, active, frame_start, locked, err, err_count
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: rebuilds H/V counters from Hsync/Vsync and checks line and frame periods.
// Optional macro VGA_RX_CDC_EN adds 2-flop synchronizers on Hsync/Vsync.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 1056,
  parameter int H_SYNC      = 128,
  parameter int H_BACK      = 88,
  parameter int H_ACTIVE    = 800,
  parameter int V_TOTAL     = 628,
  parameter int V_SYNC      = 4,
  parameter int V_BACK      = 23,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input logic               CLK40MHZ,
  input logic               rst_n,
  vga_sync_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [11:0] HT_M1    = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_TO     = 12'(2 * H_TOTAL);
  localparam logic [11:0] VT_M1    = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HS_END   = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VS_END   = 12'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

  logic        hs_in_s, vs_in_s;
  logic        hs_d_r, vs_d_r;
  logic        h_edge_s, v_edge_s, fb_s;
  logic        vs_pending_r, h_seen_r, fs_seen_r;
  logic [11:0] hcount_r, vcount_r;
  logic        fs_r, err_r;
  logic [15:0] err_count_r;
  logic        line_mis_s, frame_mis_s, to_mis_s, mismatch_s;
  state_t      state_r, state_nx_s;
  logic [7:0]  good_frames_r, good_nx_s;
  logic        locked_s, active_s;

`ifdef VGA_RX_CDC_EN
  logic [1:0] hs_sync_r, vs_sync_r;

  // Two-stage synchronizers for the asynchronous sync inputs
  always_ff @(posedge CLK40MHZ) begin
    if (!rst_n) begin
      hs_sync_r <= 2'b00;
      vs_sync_r <= 2'b00;
    end else begin
      hs_sync_r <= {hs_sync_r[0], bus.Hsync};
      vs_sync_r <= {vs_sync_r[0], bus.Vsync};
    end
  end

  assign hs_in_s = hs_sync_r[1];
  assign vs_in_s = vs_sync_r[1];
`else
  assign hs_in_s = bus.Hsync;
  assign vs_in_s = bus.Vsync;
`endif

  assign h_edge_s = hs_in_s & ~hs_d_r;
  assign v_edge_s = vs_in_s & ~vs_d_r;
  // A frame boundary is the line start that follows (or coincides with) a Vsync rise
  assign fb_s     = h_edge_s & (vs_pending_r | v_edge_s);

  assign line_mis_s  = h_edge_s & h_seen_r & (hcount_r != HT_M1);
  assign frame_mis_s = fb_s & fs_seen_r & (vcount_r != VT_M1);
  assign to_mis_s    = (hcount_r == H_TO);
  assign mismatch_s  = line_mis_s | frame_mis_s | to_mis_s;

  // Edge history, counters, pulse outputs and the saturating error count
  always_ff @(posedge CLK40MHZ) begin
    if (!rst_n) begin
      hs_d_r       <= 1'b0;
      vs_d_r       <= 1'b0;
      vs_pending_r <= 1'b0;
      h_seen_r     <= 1'b0;
      fs_seen_r    <= 1'b0;
      hcount_r     <= 12'd0;
      vcount_r     <= 12'd0;
      fs_r         <= 1'b0;
      err_r        <= 1'b0;
      err_count_r  <= 16'd0;
    end else begin
      hs_d_r <= hs_in_s;
      vs_d_r <= vs_in_s;
      if (h_edge_s) begin
        hcount_r <= 12'd0;
        h_seen_r <= 1'b1;
      end else if (hcount_r != 12'hFFF) begin
        hcount_r <= hcount_r + 12'd1;
      end
      if (fb_s) begin
        vcount_r     <= 12'd0;
        vs_pending_r <= 1'b0;
        fs_seen_r    <= 1'b1;
      end else begin
        if (h_edge_s && (vcount_r != 12'hFFF)) begin
          vcount_r <= vcount_r + 12'd1;
        end
        if (v_edge_s) begin
          vs_pending_r <= 1'b1;
        end
      end
      fs_r  <= fb_s;
      err_r <= mismatch_s;
      if (mismatch_s && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge CLK40MHZ) begin
    if (!rst_n) begin
      state_r       <= SEARCH;
      good_frames_r <= 8'd0;
    end else begin
      state_r       <= state_nx_s;
      good_frames_r <= good_nx_s;
    end
  end

  // Lock FSM next state: a mismatch always drops back to SEARCH
  always_comb begin
    state_nx_s = state_r;
    good_nx_s  = good_frames_r;
    case (state_r)
      SEARCH: begin
        if (fb_s) begin
          state_nx_s = ACQUIRE;
          good_nx_s  = 8'd0;
        end else begin
          state_nx_s = SEARCH;
        end
      end
      ACQUIRE: begin
        if (mismatch_s) begin
          state_nx_s = SEARCH;
          good_nx_s  = 8'd0;
        end else if (fb_s) begin
          good_nx_s = good_frames_r + 8'd1;
          if ((good_frames_r + 8'd1) >= LOCK_N) begin
            state_nx_s = LOCKED;
          end else begin
            state_nx_s = ACQUIRE;
          end
        end else begin
          state_nx_s = ACQUIRE;
        end
      end
      LOCKED: begin
        if (mismatch_s) begin
          state_nx_s = SEARCH;
          good_nx_s  = 8'd0;
        end else begin
          state_nx_s = LOCKED;
        end
      end
      default: begin
        state_nx_s = SEARCH;
        good_nx_s  = 8'd0;
      end
    endcase
  end

  assign locked_s = (state_r == LOCKED);
  assign active_s = locked_s
                  & (hcount_r >= HS_START) & (hcount_r < HS_END)
                  & (vcount_r >= VS_START) & (vcount_r < VS_END);

  assign bus.Hcount      = hcount_r;
  assign bus.Vcount      = vcount_r;
  assign bus.x           = active_s ? (hcount_r - HS_START) : 12'd0;
  assign bus.y           = active_s ? (vcount_r - VS_START) : 12'd0;
  assign bus.active      = active_s;
  assign bus.frame_start = fs_r;
  assign bus.locked      = locked_s;
  assign bus.err         = err_r;
  assign bus.err_count   = err_count_r;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 40x12 timing so whole frames stay short.
module tb_vga_sync_receiver;
  localparam int H_TOTAL = 40;
  localparam int H_SYNC  = 4;
  localparam int V_TOTAL = 12;
  localparam int V_SYNC  = 2;
`ifdef VGA_RX_CDC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  vga_sync_receiver_if bus();

  vga_sync_receiver #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK(4), .H_ACTIVE(24),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BACK(2), .V_ACTIVE(6),
    .LOCK_FRAMES(2)
  ) dut (
    .CLK40MHZ(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tb_h = 0;
  int tb_v = 0;
  bit short_line = 1'b0;
  int cyc = 0, fs_cnt = 0, fs_last = 0, fs_gap = 0, err_cnt = 0, lock_fs = 0;
  bit lk_prev = 1'b0;
  int e0, e1, e2, fs_mark, g;

  // Pulse and lock-edge monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (bus.frame_start) begin
      fs_cnt++;
      fs_gap  = cyc - fs_last;
      fs_last = cyc;
    end
    if (bus.err) err_cnt++;
    if (bus.locked && !lk_prev) lock_fs = fs_cnt;
    lk_prev = bus.locked;
    cyc++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock of the reference sync source; position (tb_h, tb_v) is the next one driven
  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      bus.Hsync = (tb_h < H_SYNC) ? 1'b1 : 1'b0;
      bus.Vsync = (tb_v < V_SYNC) ? 1'b1 : 1'b0;
      @(negedge clk);
      tb_h++;
      if (tb_h >= (short_line ? H_TOTAL - 1 : H_TOTAL)) begin
        tb_h = 0;
        short_line = 1'b0;
        tb_v = (tb_v == V_TOTAL - 1) ? 0 : tb_v + 1;
      end
    end
  endtask

  task automatic goto(input int h, input int v);
    int guard = 0;
    while (!(tb_h == h && tb_v == v) && guard < 2 * H_TOTAL * V_TOTAL) begin
      drive(1);
      guard++;
    end
  endtask

  task automatic next_frame();
    drive(1);
    goto(0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Hsync = 1'b0;
    bus.Vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hcount", int'(bus.Hcount), 0);
    chk("rst_vcount", int'(bus.Vcount), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_active", int'(bus.active), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_errcnt", int'(bus.err_count), 0);
    chk("rst_fs", int'(bus.frame_start), 0);
    rst_n = 1'b1;

    // Four nominal frames: lock on the third frame_start
    drive(4 * H_TOTAL * V_TOTAL);
    chk("nom_fs_cnt", fs_cnt, 4);
    chk("nom_fs_gap", fs_gap, H_TOTAL * V_TOTAL);
    chk("nom_lock_at", lock_fs, 3);
    chk("nom_locked", int'(bus.locked), 1);
    chk("nom_err_pulses", err_cnt, 0);
    chk("nom_errcnt", int'(bus.err_count), 0);

    // Active window is x 8..31, y 4..9
    goto(7 + LAT, 4);
    chk("win_h7_active", int'(bus.active), 0);
    chk("win_h7_x", int'(bus.x), 0);
    goto(8 + LAT, 4);
    chk("win_first_hcount", int'(bus.Hcount), 8);
    chk("win_first_vcount", int'(bus.Vcount), 4);
    chk("win_first_active", int'(bus.active), 1);
    chk("win_first_x", int'(bus.x), 0);
    chk("win_first_y", int'(bus.y), 0);
    goto(31 + LAT, 9);
    chk("win_last_active", int'(bus.active), 1);
    chk("win_last_x", int'(bus.x), 23);
    chk("win_last_y", int'(bus.y), 5);
    goto(32 + LAT, 9);
    chk("win_hend_active", int'(bus.active), 0);
    chk("win_hend_x", int'(bus.x), 0);
    goto(20 + LAT, 10);
    chk("win_vend_active", int'(bus.active), 0);
    chk("win_vend_y", int'(bus.y), 0);

    // One short line while locked
    goto(0, 3);
    e0 = err_cnt;
    short_line = 1'b1;
    goto(0, 4);
    drive(LAT);
    chk("short_err", int'(bus.err), 1);
    chk("short_locked", int'(bus.locked), 0);
    chk("short_errcnt", int'(bus.err_count), 1);
    drive(1);
    chk("short_err_once", int'(bus.err), 0);
    fs_mark = fs_cnt;
    goto(0, 0);
    next_frame();
    next_frame();
    chk("relock_not_yet", int'(bus.locked), 0);
    chk("relock_fs_before", fs_cnt - fs_mark, 2);
    drive(LAT + 2);
    chk("relock_locked", int'(bus.locked), 1);
    chk("relock_at", lock_fs - fs_mark, 3);
    chk("short_err_pulses", err_cnt - e0, 1);

    // Hsync stuck low: one timeout error, counter saturates
    goto(10, 2);
    bus.Hsync = 1'b0;
    bus.Vsync = 1'b0;
    e1 = int'(bus.err_count);
    g = 0;
    while (bus.Hcount != 12'd80 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("to_reach80", int'(bus.Hcount), 80);
    chk("to_err_pre", int'(bus.err), 0);
    @(negedge clk);
    chk("to_err", int'(bus.err), 1);
    chk("to_hcount", int'(bus.Hcount), 81);
    chk("to_locked", int'(bus.locked), 0);
    chk("to_errcnt", int'(bus.err_count), e1 + 1);
    g = 0;
    while (bus.Hcount != 12'hFFF && g < 5000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    chk("to_sat", int'(bus.Hcount), 4095);
    chk("to_errcnt_once", int'(bus.err_count), e1 + 1);
    chk("to_search", int'(bus.locked), 0);

    // Restart with Vsync and Hsync rising together: line and frame mismatch count once
    tb_h = 0;
    tb_v = 0;
    drive(LAT);
    chk("rs_err", int'(bus.err), 1);
    chk("rs_fs", int'(bus.frame_start), 1);
    chk("rs_vcount", int'(bus.Vcount), 0);
    chk("rs_hcount", int'(bus.Hcount), 0);
    chk("rs_errcnt", int'(bus.err_count), e1 + 2);
    goto(LAT, 1);
    chk("rs_vcount_next", int'(bus.Vcount), 1);
    next_frame();
    next_frame();
    next_frame();
    drive(LAT + 2);
    chk("rs_relocked", int'(bus.locked), 1);

    // One-cycle reset mid-line while locked
    goto(15, 5);
    rst_n = 1'b0;
    drive(1);
    rst_n = 1'b1;
    chk("mr_hcount", int'(bus.Hcount), 0);
    chk("mr_vcount", int'(bus.Vcount), 0);
    chk("mr_locked", int'(bus.locked), 0);
    chk("mr_active", int'(bus.active), 0);
    chk("mr_x", int'(bus.x), 0);
    chk("mr_y", int'(bus.y), 0);
    chk("mr_err", int'(bus.err), 0);
    chk("mr_fs", int'(bus.frame_start), 0);
    chk("mr_errcnt", int'(bus.err_count), 0);
    e2 = err_cnt;
    goto(0, 6);
    drive(LAT + 1);
    chk("mr_first_edge_err", int'(bus.err), 0);
    next_frame();
    drive(LAT + 2);
    chk("mr_errcnt_after", int'(bus.err_count), 0);
    chk("mr_err_pulses", err_cnt - e2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the 800x600@60Hz VGA timing generator.
- Consumes Hsync/Vsync, regenerates horizontal/vertical counters and pixel coordinates, and checks line/frame periods against nominal timing.
- Reports lock status and errors; provides a saturating error count.
- Used as an on-chip timing monitor and as a capture front-end, clocked by CLK40MHZ.

Parameters:
- H_TOTAL, 1056, pixel clocks per line
- H_SYNC, 128, Hsync width
- H_BACK, 88, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- V_TOTAL, 628, lines per frame
- V_SYNC, 4, Vsync width in lines
- V_BACK, 23, vertical back porch in lines
- V_ACTIVE, 600, visible lines
- LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
- CLK40MHZ  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- Hsync  in  1  horizontal sync, active high
- Vsync  in  1  vertical sync, active high
- Hcount  out  12  recovered horizontal counter
- Vcount  out  12  recovered vertical counter
- x  out  12  active-area x coordinate; 0 outside the active area
- y  out  12  active-area y coordinate; 0 outside the active area
- active  out  1  pixel is inside the visible window and the receiver is locked
- frame_start  out  1  one-cycle pulse at the frame boundary
- locked  out  1  timing lock
- err  out  1  one-cycle pulse on any timing mismatch
- err_count  out  16  saturating mismatch count

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Hcount=0, Vcount=0; hs_d, vs_d, vs_pending, h_seen all 0.
  - FSM=SEARCH, good_frames=0, err_count=0.
  - frame_start=0, err=0, so locked=0, active=0, x=y=0.
  - A mid-frame reset discards all state; no err pulse is generated.
- Edge detection:
  - hs_d and vs_d register Hsync and Vsync each cycle.
  - h_edge = Hsync & ~hs_d.
  - v_edge = Vsync & ~vs_d.
- Horizontal counter:
  - On h_edge, Hcount<=0 on the next edge, so Hcount=0 exactly one cycle after Hsync rises.
  - Otherwise Hcount increments, saturating at 4095.
- Line check:
  - On h_edge with h_seen=1, mismatch if Hcount != H_TOTAL-1.
  - The first h_edge after reset only sets h_seen.
- Timeout: Hcount reaching 2*H_TOTAL is a mismatch, flagged once; it re-arms on the next h_edge.
- Vertical counter:
  - v_edge sets vs_pending.
  - On h_edge with vs_pending (or v_edge in the same cycle):
    - Vcount<=0 and clear vs_pending.
    - Pulse frame_start next cycle.
    - If a previous frame_start has occurred, mismatch if Vcount != V_TOTAL-1.
  - On any other h_edge, Vcount increments, saturating at 4095.
- FSM states SEARCH, ACQUIRE, LOCKED:
  - SEARCH -> ACQUIRE on frame_start, with good_frames=0.
  - ACQUIRE: each frame_start with no mismatch since the previous one increments good_frames; reaching LOCK_FRAMES -> LOCKED.
  - Any mismatch in ACQUIRE or LOCKED -> SEARCH next cycle.
  - locked=1 only in LOCKED.
- Errors:
  - err pulses one cycle after each mismatch, in all states.
  - err_count increments and saturates at 65535.
  - Simultaneous line and frame mismatch counts once.
- Coordinates (combinational from registers):
  - Horizontal window: hs = H_SYNC + H_BACK.
  - Vertical window: vs = V_SYNC + V_BACK.
  - active=locked & hs<=Hcount<hs+H_ACTIVE & vs<=Vcount<vs+V_ACTIVE.
  - x=Hcount-hs, y=Vcount-vs when active, else 0.
- Arithmetic is 12-bit unsigned; parameters must satisfy total < 2048.

Optional Feature:
- Macro VGA_RX_CDC_EN.
- Defined: Hsync/Vsync each pass through a 2-flop synchronizer before edge detection. All counter responses shift 2 cycles later (Hcount=0 three cycles after Hsync rises). Synchronizer flops reset to 0.
- Undefined: inputs are used directly, with the 1-cycle latency above. Inputs must be synchronous to CLK40MHZ.

Test Plan:
- Nominal 800x600 stimulus (1056x628) for 4 frames -> frame_start pulses every 663168 cycles; locked rises on the 3rd frame_start (SEARCH, then 2 clean frames); err_count=0.
- Locked, pixel at Hcount=216, Vcount=27 -> active=1, x=0, y=0. At Hcount=1015, Vcount=626 -> x=799, y=599. At Hcount=1016 -> active=0, x=0.
- One short line of 1055 cycles while locked -> err pulse once; locked=0 the next cycle; err_count=1; relock after LOCK_FRAMES+1 frame_starts.
- Hsync held low for 2112 cycles -> single err at Hcount=2112; Hcount saturates at 4095; FSM=SEARCH.
- rst_n low for 1 cycle mid-line while locked -> all outputs 0 the next cycle; first subsequent h_edge produces no err.
- Vsync rising edge coincident with an h_edge -> Vcount=0 and frame_start on that boundary with no extra line counted; with VGA_RX_CDC_EN, same results delayed by 2 cycles.
